// File: rtl/sram_access_arbiter.sv
// sram_access_arbiter: shares one single-port 8K x 32 SRAM between a playback reader (port 0) and a recorder/loader (port 1)
//   CLK, RST                   clock, asynchronous active-high reset
//   req/we/addr/wdata 0 and 1  requests, held until the matching ack
//   ack0/ack1                  one-cycle accept pulses
//   rvalid0/rvalid1, rdata     one-cycle read-return pulses and the shared read data
//   sram_addr/wdata/we/ce_req  SRAM request, driven for exactly one cycle per access
//   sram_rdata                 registered SRAM read data, valid in CAPTURE
//   busy                       high whenever an access is in flight
// Build option: SRAM_ARB_FIXED_PRIORITY_EN makes port 0 win every tie instead of round-robin.
module sram_access_arbiter #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic              rvalid0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    output logic              sram_we,
    output logic              sram_ce_req,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE} state_t;
    state_t state, state_nx;
    logic grant, pick1, cur, cur_we, rd_done;
`ifndef SRAM_ARB_FIXED_PRIORITY_EN
    logic last;
`endif
    always_comb begin
        state_nx = state == IDLE ? ((req0 || req1) ? ACCESS : IDLE) : state == ACCESS ? CAPTURE : IDLE;
        grant    = state == IDLE && (req0 || req1);
`ifdef SRAM_ARB_FIXED_PRIORITY_EN
        pick1    = req1 && !req0;
`else
        // last == 1 means port 1 was served most recently, so port 0 takes the tie
        pick1    = req1 && (!req0 || !last);
`endif
        rd_done  = state == CAPTURE && !cur_we;
    end
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nx;
    end
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            rvalid0     <= 1'b0;
            rvalid1     <= 1'b0;
            rdata       <= '0;
            sram_addr   <= '0;
            sram_wdata  <= '0;
            sram_we     <= 1'b0;
            sram_ce_req <= 1'b0;
            cur         <= 1'b0;
            cur_we      <= 1'b0;
`ifndef SRAM_ARB_FIXED_PRIORITY_EN
            last        <= 1'b1;
`endif
        end else begin
            ack0        <= grant && !pick1;
            ack1        <= grant && pick1;
            sram_we     <= grant && (pick1 ? we1 : we0);
            sram_ce_req <= grant;
            rvalid0     <= rd_done && !cur;
            rvalid1     <= rd_done && cur;
            if (grant) begin
                sram_addr  <= pick1 ? addr1 : addr0;
                sram_wdata <= pick1 ? wdata1 : wdata0;
                cur        <= pick1;
                cur_we     <= pick1 ? we1 : we0;
`ifndef SRAM_ARB_FIXED_PRIORITY_EN
                last       <= pick1;
`endif
            end
            if (rd_done) rdata <= sram_rdata;
        end
    end
    assign busy = state != IDLE;
endmodule

// File: tb/tb_sram_access_arbiter.sv
// tb_sram_access_arbiter: table-driven and scoreboarded checks of sram_access_arbiter against a behavioural SRAM
module tb_sram_access_arbiter;
    logic        CLK = 1'b0, RST = 1'b1;
    logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [12:0] addr0 = '0, addr1 = '0;
    logic [31:0] wdata0 = '0, wdata1 = '0;
    logic        ack0, rvalid0, ack1, rvalid1, sram_we, sram_ce_req, busy;
    logic [31:0] rdata, sram_wdata, sram_rdata = '0;
    logic [12:0] sram_addr;

    sram_access_arbiter dut (
        .CLK(CLK), .RST(RST),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rvalid0(rvalid0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rvalid1(rvalid1),
        .rdata(rdata), .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_we(sram_we),
        .sram_ce_req(sram_ce_req), .sram_rdata(sram_rdata), .busy(busy)
    );

    always #5 CLK = ~CLK;

`ifdef SRAM_ARB_FIXED_PRIORITY_EN
    localparam bit FIXED_PRI = 1'b1;
`else
    localparam bit FIXED_PRI = 1'b0;
`endif

    function automatic logic [31:0] init_val(input int a);
        return 32'hC0DE0000 | a;
    endfunction

    // behavioural SRAM: samples on the edge where ce_req is high, read data registered
    logic [31:0] mem [8192];
    initial for (int i = 0; i < 8192; i++) mem[i] = init_val(i);
    always @(posedge CLK)
        if (sram_ce_req) begin
            if (sram_we) mem[sram_addr] <= sram_wdata;
            else         sram_rdata     <= mem[sram_addr];
        end

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_vec = 0, n_bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    typedef struct {bit port; logic [31:0] data; int due;} exp_t;
    exp_t q[$];
    exp_t e;

    always @(negedge CLK)
        if (!RST) begin
            if (ack0 && ack1) check("ack_exclusive", {ack0, ack1}, 2'b00);
            if (rvalid0 && rvalid1) check("rvalid_exclusive", {rvalid0, rvalid1}, 2'b00);
            if (rvalid0 || rvalid1) begin
                if (q.size() == 0) check("rvalid_unexpected", {rvalid0, rvalid1}, 2'b00);
                else begin
                    e = q.pop_front();
                    check("rvalid_port", rvalid1, e.port);
                    check("rdata", rdata, e.data);
                    check("rvalid_latency", cyc, e.due);
                end
            end
        end

    task automatic wait_drain();
        for (int t = 0; t < 30 && q.size() != 0; t++) @(negedge CLK);
        check("drain", q.size(), 0);
    endtask

    // one access on port p; returns the cycle count at the ack edge (-1 on timeout)
    task automatic access(input bit p, input bit w, input logic [12:0] a, input logic [31:0] d,
                          input logic [31:0] exp, output int ca);
        bit got = 1'b0;
        ca = -1;
        if (p) begin req1 = 1; we1 = w; addr1 = a; wdata1 = d; end
        else   begin req0 = 1; we0 = w; addr0 = a; wdata0 = d; end
        for (int t = 0; t < 20; t++) begin
            @(negedge CLK);
            if (p ? ack1 : ack0) begin got = 1'b1; break; end
        end
        if (!got) begin
            check("ack_timeout", 0, 1);
            req0 = 0; req1 = 0;
            return;
        end
        ca = cyc;
        check("ack_other", p ? ack0 : ack1, 0);
        check("ce_access", sram_ce_req, 1);
        check("we_access", sram_we, w);
        check("addr_access", sram_addr, a);
        if (w) check("wdata_access", sram_wdata, d);
        check("busy_access", busy, 1);
        if (!w) q.push_back('{p, exp, ca + 2});
        @(posedge CLK); #1;
        if (p) begin req1 = 0; addr1 = ~a; wdata1 = ~d; end
        else   begin req0 = 0; addr0 = ~a; wdata0 = ~d; end
        @(negedge CLK);
        check("ce_capture", {sram_ce_req, sram_we}, 2'b00);
        check("addr_hold", sram_addr, a);
        check("busy_capture", busy, 1);
    endtask

    typedef struct {bit port; bit we; logic [12:0] addr; logic [31:0] wdata; logic [31:0] exp;} vec_t;
    vec_t vt[13];

    initial begin
        int ca, prev;
        bit got;
        vt[0]  = '{1'b1, 1'b1, 13'h0005, 32'hDEADBEEF, 32'h0};
        vt[1]  = '{1'b0, 1'b0, 13'h0005, 32'h0,        32'hDEADBEEF};
        vt[2]  = '{1'b1, 1'b1, 13'h1FFF, 32'h12345678, 32'h0};
        vt[3]  = '{1'b0, 1'b0, 13'h1FFF, 32'h0,        32'h12345678};
        vt[4]  = '{1'b0, 1'b1, 13'h0000, 32'hA5A5A5A5, 32'h0};
        vt[5]  = '{1'b1, 1'b0, 13'h0000, 32'h0,        32'hA5A5A5A5};
        vt[6]  = '{1'b1, 1'b0, 13'h0010, 32'h0,        32'hC0DE0010};
        vt[7]  = '{1'b0, 1'b1, 13'h0010, 32'h00000000, 32'h0};
        vt[8]  = '{1'b1, 1'b0, 13'h0010, 32'h0,        32'h00000000};
        vt[9]  = '{1'b0, 1'b0, 13'h0005, 32'h0,        32'hDEADBEEF};
        vt[10] = '{1'b0, 1'b0, 13'h1FFF, 32'h0,        32'h12345678};
        vt[11] = '{1'b0, 1'b0, 13'h0000, 32'h0,        32'hA5A5A5A5};
        vt[12] = '{1'b0, 1'b0, 13'h0123, 32'h0,        32'hC0DE0123};

        repeat (3) @(negedge CLK);
        check("rst_ctl", {ack0, ack1, rvalid0, rvalid1, sram_we, sram_ce_req, busy}, 0);
        check("rst_rdata", rdata, 0);
        check("rst_addr", sram_addr, 0);
        check("rst_wdata", sram_wdata, 0);
        RST = 0;
        @(negedge CLK);

        // both ports request reads from reset: port 0 first, then alternation (or port 0 only when fixed)
        req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 13'h0010; addr1 = 13'h1FFF;
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            got = 1'b0;
            for (int t = 0; t < 10; t++) begin
                @(negedge CLK);
                if (ack0 || ack1) begin got = 1'b1; break; end
            end
            if (!got) begin check("rr_timeout", 0, 1); break; end
            check("rr_port", ack1, FIXED_PRI ? 1'b0 : 1'(k % 2));
            if (k > 0) check("rr_spacing", cyc - prev, 3);
            prev = cyc;
            q.push_back('{ack1, init_val(ack1 ? 32'h1FFF : 32'h0010), cyc + 2});
        end
        @(posedge CLK); #1;
        req0 = 0; req1 = 0;
        wait_drain();

        // table vectors, issued back to back
        prev = 0;
        for (int i = 0; i < 13; i++) begin
            access(vt[i].port, vt[i].we, vt[i].addr, vt[i].wdata, vt[i].exp, ca);
            if (i > 0 && ca >= 0 && prev >= 0) check("b2b_spacing", ca - prev, 3);
            prev = ca;
        end
        wait_drain();

        // reset in the ACCESS cycle of a read: everything clears at once, no rvalid follows
        req0 = 1; we0 = 0; addr0 = 13'h0005;
        got = 1'b0;
        for (int t = 0; t < 10; t++) begin
            @(negedge CLK);
            if (ack0) begin got = 1'b1; break; end
        end
        check("mid_ack", got, 1);
        #2 RST = 1;
        #1;
        check("mid_rst_ctl", {ack0, ack1, rvalid0, rvalid1, sram_we, sram_ce_req, busy}, 0);
        check("mid_rst_addr", sram_addr, 0);
        check("mid_rst_rdata", rdata, 0);
        @(posedge CLK); #1;
        req0 = 0;
        repeat (2) @(negedge CLK);
        RST = 0;
        repeat (6) @(negedge CLK);
        check("post_rst_idle", busy, 0);
        access(1'b0, 1'b0, 13'h0005, 32'h0, 32'hDEADBEEF, ca);
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
